// File: rtl/shift_window_pkg.sv
// Shared constants and sizing helpers for the sliding-window accumulator.
package shift_window_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_DEPTH = 8;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned bits;
      bits = 0;
      for (int unsigned p = 1; p < value; p = p << 1) bits++;
      return bits;
   endfunction

   // Accumulator width: one extra bit per doubling of the window.
   function automatic int unsigned sum_width(input int unsigned width, input int unsigned depth);
      return width + clog2(depth);
   endfunction

   // Fill counter spans 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/shift_window_ring.sv
// DEPTH x WIDTH sample ring with a wrapping write pointer; read of the oldest
// slot is asynchronous and sees the value before this cycle's write.
module shift_window_ring
   import shift_window_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             we,
   input  logic             clr_ptr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata_oldest
);

   localparam int unsigned AW = clog2(DEPTH);

   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    waddr_c;
   logic [WIDTH-1:0] mem [DEPTH];

   // A restart with a sample writes it to slot 0 as the first of the new window.
   assign waddr_c = clr_ptr ? '0 : wptr_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
      end else if (we) begin
         wptr_q <= waddr_c + AW'(1);
      end else if (clr_ptr) begin
         wptr_q <= '0;
      end
   end

   // Contents are never reset; the fill counter masks stale entries.
   always_ff @(posedge clock) begin
      if (we) mem[waddr_c] <= wdata;
   end

   assign rdata_oldest = mem[wptr_q];

endmodule

// File: rtl/shift_window_sum.sv
// Streaming sliding-window sum over the last DEPTH accepted samples.
// Optional window average output enabled by SHIFT_WINDOW_AVG_EN.
module shift_window_sum
   import shift_window_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   localparam int unsigned SUM_WIDTH = sum_width(WIDTH, DEPTH)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        ivalid,
   input  logic signed [WIDTH-1:0]     idata,
   input  logic                        iclear,
   output logic                        ovalid,
   output logic signed [SUM_WIDTH-1:0] osum,
   output logic                        ofull
`ifdef SHIFT_WINDOW_AVG_EN
   ,
   output logic signed [WIDTH-1:0]     oavg
`endif
);

   localparam int unsigned CW = cnt_width(DEPTH);

   logic [CW-1:0]              cnt_q, cnt_nxt;
   logic signed [SUM_WIDTH-1:0] sum_nxt;
   logic                       valid_nxt;
   logic                       full_nxt;
   logic                       full_c;
   logic [WIDTH-1:0]           ring_oldest;
   logic [WIDTH-1:0]           oldest_c;

   shift_window_ring #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_ring (
      .clock       (clock),
      .reset       (reset),
      .we          (ivalid),
      .clr_ptr     (iclear),
      .wdata       (idata),
      .rdata_oldest(ring_oldest)
   );

   assign full_c   = (cnt_q == CW'(DEPTH));
   assign oldest_c = full_c ? ring_oldest : '0;

   // Next-state: clear has priority; a concurrent sample opens the new window.
   always_comb begin
      sum_nxt   = osum;
      cnt_nxt   = cnt_q;
      valid_nxt = 1'b0;
      if (iclear) begin
         if (ivalid) begin
            sum_nxt   = SUM_WIDTH'(idata);
            cnt_nxt   = CW'(1);
            valid_nxt = 1'b1;
         end else begin
            sum_nxt = '0;
            cnt_nxt = '0;
         end
      end else if (ivalid) begin
         sum_nxt   = osum + SUM_WIDTH'(idata) - SUM_WIDTH'($signed(oldest_c));
         cnt_nxt   = full_c ? cnt_q : cnt_q + CW'(1);
         valid_nxt = 1'b1;
      end
      full_nxt = (cnt_nxt == CW'(DEPTH));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         osum   <= '0;
         ovalid <= 1'b0;
         ofull  <= 1'b0;
      end else begin
         cnt_q  <= cnt_nxt;
         osum   <= sum_nxt;
         ovalid <= valid_nxt;
         ofull  <= full_nxt;
      end
   end

`ifdef SHIFT_WINDOW_AVG_EN
   localparam int unsigned LOG2D = clog2(DEPTH);

   // Arithmetic shift rounds toward -inf; registered alongside osum.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         oavg <= '0;
      end else begin
         oavg <= WIDTH'(sum_nxt >>> LOG2D);
      end
   end
`endif

endmodule

// File: doc/shift_window_sum.md
# shift_window_sum

Streaming sliding-window accumulator placed directly downstream of the shift-tap delay stage. It accepts one signed sample per `ivalid` cycle. It keeps the last DEPTH accepted samples in an internal ring buffer and emits the running window sum one cycle after each accepted sample. Downstream filter and threshold blocks consume `osum` as a moving-sum / moving-average feed.

## Interface
- `WIDTH`, 32, sample width; two's-complement signed.
- `DEPTH`, 8, window length in samples; ≥2 and a power of two.
- `SUM_WIDTH`, WIDTH+clog2(DEPTH), accumulator and output width; derived, not overridden.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ivalid`  in  1  sample strobe; `idata` is accepted on every cycle this is high.
- `idata`  in  WIDTH  input sample, signed.
- `iclear`  in  1  synchronous window restart.
- `ovalid`  out  1  one-cycle pulse: `osum` updated.
- `osum`  out  SUM_WIDTH  signed sum of the samples in the current window.
- `ofull`  out  1  level: DEPTH samples accumulated since reset/clear.
- `oavg`  out  WIDTH  signed window average; present only with `SHIFT_WINDOW_AVG_EN`.

## Operation
- Reset (`reset`=0, async): `ovalid`=0, `osum`=0, `ofull`=0, `oavg`=0, fill count=0, write pointer=0. Ring contents are not cleared; they are masked by the fill count.
- Accepted sample: `ivalid`=1.
  - oldest = `ring[wptr]` if count==DEPTH, else 0.
  - `ring[wptr]` <= `idata`; `wptr` <= `wptr`+1, wrapping DEPTH-1 -> 0.
  - sum <= sum + sext(`idata`) - sext(oldest).
  - count <= min(count+1, DEPTH).
- Arithmetic is full-precision signed at SUM_WIDTH. Overflow is impossible by construction: the worst case is DEPTH·(-2^(WIDTH-1)).
- `ivalid`=0: all state holds and `ovalid`=0. Gaps of any length are legal.
- `iclear`=1, `ivalid`=0: sum<=0, count<=0, `ofull`<=0, `wptr`<=0, no `ovalid` pulse.
- `iclear`=1 and `ivalid`=1 together: clear wins and the current sample becomes the first of the new window. Result: sum<=sext(`idata`), count<=1, `ovalid` pulses, `ofull`=0.
- `ofull` asserts in the cycle in which count reaches DEPTH. It holds until reset or clear.
- Window fill is tracked by a counter of 0..DEPTH (clog2(DEPTH)+1 bits) and does not rely on the ring contents.

## Timing
- Latency is 1 cycle: a sample accepted at edge N gives `osum`/`ovalid`/`ofull` at edge N+1 (visible after edge N).
- Throughput is one sample per cycle, and there is no back-pressure.
- `ovalid` is high for exactly one cycle per accepted sample. `osum` stays stable between pulses.
- The ring buffer reads and writes the same address in one cycle, with read-before-write. It is a register array or a distributed RAM with an asynchronous read; there is no extra pipeline stage.
- Deasserting reset is safe mid-stream. The first sample after deassertion is treated as sample 1.

## Configuration
- `SHIFT_WINDOW_AVG_EN` defined:
  - Adds the `oavg` port: `osum` >>> clog2(DEPTH), an arithmetic shift truncated toward -inf, lower WIDTH bits.
  - `oavg` is registered on the same edge as `osum`, so it has the same 1-cycle latency.
- Undefined: the `oavg` port and its logic are absent; everything else is unchanged.

## Structure
- Package `shift_window_pkg` holds:
  - the `clog2` constant function;
  - the SUM_WIDTH derivation;
  - the fill-count width constant.
- Sub-module `shift_window_ring` holds the DEPTH×WIDTH ring buffer and its wrapping write pointer:
  - inputs: `we`, `clr_ptr`, `wdata`;
  - output: `rdata_oldest`.
- The top level holds the accumulator, fill counter, clear priority logic and optional averager.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- Fill and slide: feed 1,2,3,4,5,6 on consecutive cycles -> `osum` 1,3,6,10,14,18 one cycle after each sample; `ofull` rises with the 10; `oavg` (macro on) = 0,0,1,2,3,4.
- Negative extreme: feed -128 ×4 -> `osum` = -512 (10-bit 0x200), no overflow; then +127 ×4 -> `osum` returns to 508.
- Gapped input: samples 5,_,_,7,_,9 (`ivalid` gaps) -> `osum` 5,12,21, held between pulses; `ovalid` counts exactly 3 pulses.
- Clear priority: after a full window, `iclear` with `ivalid` and `idata`=3 -> `osum`=3, `ofull`=0. Then 1,1,1 -> 4,5,6 with `ofull` rising at 6. `iclear` alone -> `osum`=0 and no `ovalid`.
- Async reset mid-stream: assert `reset`=0 between edges while the window is full -> all outputs read 0 immediately. After release, feed 2 -> `osum`=2 (stale ring masked).
- Wrap-around soak: 1000 random samples with random `ivalid`/`iclear` -> `osum` matches a reference model of the last ≤DEPTH samples on every `ovalid`.
